// File: rtl/mul_arb_if.sv
// mul_arb_if: requester and multiplier-side signals of the shared-multiplier arbiter.
interface mul_arb_if #(
    parameter int XLEN = 64,
    parameter int TAGW = 4
);
    logic [1:0]        ReqValid, ReqReady;
    logic [2*XLEN-1:0] ReqA, ReqB;
    logic [5:0]        ReqFunct3;
    logic [2*TAGW-1:0] ReqTag;
    logic [1:0]        Kill, ResValid, ResReady;
    logic [2*XLEN-1:0] ResData;
    logic [2*TAGW-1:0] ResTag;
    logic [XLEN-1:0]   MulSrcA, MulSrcB;
    logic [2:0]        MulFunct3;
    logic              MulStallM, MulFlushM;
    logic [2*XLEN-1:0] MulProdM;

    modport slave (
        input  ReqValid, ReqA, ReqB, ReqFunct3, ReqTag, Kill, ResReady, MulProdM,
        output ReqReady, ResValid, ResData, ResTag, MulSrcA, MulSrcB, MulFunct3, MulStallM, MulFlushM
    );
    modport master (
        output ReqValid, ReqA, ReqB, ReqFunct3, ReqTag, Kill, ResReady, MulProdM,
        input  ReqReady, ResValid, ResData, ResTag, MulSrcA, MulSrcB, MulFunct3, MulStallM, MulFlushM
    );
endinterface

// File: rtl/mul_arb.sv
// mul_arb: round-robin sharing of one pipelined multiplier between two requesters,
// with a Memory-stage shadow register and a 2-entry result FIFO per requester.
module mul_arb #(
    parameter int XLEN = 64,
    parameter int TAGW = 4
) (
    input logic   clk,
    input logic   reset,
    mul_arb_if.slave bus
);
    logic              rst;
    logic [1:0]        occ [2];
    logic [XLEN-1:0]   fd [2][2];
    logic [TAGW-1:0]   ft [2][2];
    logic              sh_v, sh_own, ptr;
    logic [1:0]        sh_f;
    logic [TAGW-1:0]   sh_tag;
    logic [1:0]        infl, pop, push, ok, rdy, gnt, wi;
    logic [XLEN-1:0]   ret;

    assign rst = !reset;

    always_comb begin
        ret = sh_f == 2'b00 ? bus.MulProdM[XLEN-1:0] : bus.MulProdM[2*XLEN-1:XLEN];
        for (int i = 0; i < 2; i++) begin
            infl[i] = sh_v && sh_own == 1'(i);
            pop[i]  = bus.ResValid[i] & bus.ResReady[i];
            push[i] = infl[i] & !bus.Kill[i];
            ok[i]   = ({1'b0, occ[i]} + {2'b0, infl[i]} - {2'b0, pop[i]}) < 3'd2 && !bus.Kill[i];
            wi[i]   = occ[i] - {1'b0, pop[i]} != 2'd0;
        end
        // A freed FIFO slot (pop) is reusable in the same cycle, hence ResReady feeds ReqReady.
        rdy[0] = !rst && ok[0] && (!ptr || !(bus.ReqValid[1] && ok[1]));
        rdy[1] = !rst && ok[1] && (ptr || !(bus.ReqValid[0] && ok[0]));
        gnt    = bus.ReqValid & rdy;
    end

    assign bus.ReqReady  = rdy;
    assign bus.ResValid  = rst ? 2'b00 : {occ[1] != 2'd0, occ[0] != 2'd0};
    assign bus.ResData   = rst ? '0 : {fd[1][0], fd[0][0]};
    assign bus.ResTag    = rst ? '0 : {ft[1][0], ft[0][0]};
    assign bus.MulSrcA   = gnt[1] ? bus.ReqA[XLEN +: XLEN] : gnt[0] ? bus.ReqA[0 +: XLEN] : '0;
    assign bus.MulSrcB   = gnt[1] ? bus.ReqB[XLEN +: XLEN] : gnt[0] ? bus.ReqB[0 +: XLEN] : '0;
    assign bus.MulFunct3 = gnt[1] ? bus.ReqFunct3[5:3] : gnt[0] ? bus.ReqFunct3[2:0] : 3'b000;
    assign bus.MulStallM = ~|gnt;
    assign bus.MulFlushM = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_v   <= 1'b0;
            sh_own <= 1'b0;
            sh_f   <= 2'b00;
            sh_tag <= '0;
            ptr    <= 1'b0;
        end else begin
            sh_v   <= |gnt;
            sh_own <= gnt[1];
            sh_f   <= gnt[1] ? bus.ReqFunct3[4:3] : gnt[0] ? bus.ReqFunct3[1:0] : 2'b00;
            sh_tag <= gnt[1] ? bus.ReqTag[TAGW +: TAGW] : gnt[0] ? bus.ReqTag[0 +: TAGW] : '0;
            if (|gnt)
                ptr <= !gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            occ[i] <= (rst || bus.Kill[i]) ? 2'd0 : occ[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            if (rst) begin
                fd[i][0] <= '0;
                fd[i][1] <= '0;
                ft[i][0] <= '0;
                ft[i][1] <= '0;
            end else if (!bus.Kill[i]) begin
                if (pop[i]) begin
                    fd[i][0] <= fd[i][1];
                    ft[i][0] <= ft[i][1];
                end
                // Push lands behind whatever survives this cycle's pop.
                if (push[i]) begin
                    fd[i][wi[i]] <= ret;
                    ft[i][wi[i]] <= sh_tag;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: random and directed stimulus for mul_arb against a queue-based result model.
module tb_mul_arb;
    localparam int XL = 32;
    localparam int TW = 4;

    typedef struct {
        logic [XL-1:0] d;
        logic [TW-1:0] t;
        int            rdy;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_arb_if #(.XLEN(XL), .TAGW(TW)) bus();
    mul_arb #(.XLEN(XL), .TAGW(TW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mulf(input logic [XL-1:0] a, input logic [XL-1:0] b, input logic [1:0] f);
        logic [65:0] sa, sb, p;
        sa = (f == 2'b01 || f == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
        sb = (f == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
        p  = sa * sb;
        return p[63:0];
    endfunction

    function automatic logic [XL-1:0] resf(input logic [XL-1:0] a, input logic [XL-1:0] b, input logic [1:0] f);
        logic [63:0] p;
        p = mulf(a, b, f);
        return f == 2'b00 ? p[31:0] : p[63:32];
    endfunction

    // External multiplier: Memory register loads only when not stalled.
    logic [2*XL-1:0] prod = '0;
    always @(posedge clk)
        if (!bus.MulStallM)
            prod <= mulf(bus.MulSrcA, bus.MulSrcB, bus.MulFunct3[1:0]);
    assign bus.MulProdM = prod;

    ent_t       q [2][$];
    logic       mptr = 1'b0;
    logic [1:0] ev, pp, okm, er, eg;
    int         gi;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("rst_reqready", bus.ReqReady, 0);
            chk("rst_resvalid", bus.ResValid, 0);
            chk("rst_resdata", bus.ResData, 0);
            chk("rst_restag", bus.ResTag, 0);
            chk("rst_stall", bus.MulStallM, 1);
            chk("rst_srca", bus.MulSrcA, 0);
            q[0].delete();
            q[1].delete();
            mptr = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                ev[i] = q[i].size() > 0 && q[i][0].rdy <= cyc;
                if (ev[i]) begin
                    chk($sformatf("resdata%0d", i), bus.ResData[i*XL +: XL], q[i][0].d);
                    chk($sformatf("restag%0d", i), bus.ResTag[i*TW +: TW], q[i][0].t);
                end
                pp[i]  = ev[i] & bus.ResReady[i];
                okm[i] = (q[i].size() - int'(pp[i])) < 2 && !bus.Kill[i];
                if (dut.push[i])
                    chk($sformatf("push_room%0d", i), dut.occ[i] == 2'd2, 0);
            end
            chk("resvalid", bus.ResValid, ev);
            er[0] = okm[0] && (mptr == 1'b0 || !(bus.ReqValid[1] && okm[1]));
            er[1] = okm[1] && (mptr == 1'b1 || !(bus.ReqValid[0] && okm[0]));
            chk("reqready", bus.ReqReady, er);
            eg = er & bus.ReqValid;
            gi = eg[1] ? 1 : 0;
            chk("stall", bus.MulStallM, eg == 2'b00);
            chk("srca", bus.MulSrcA, eg != 0 ? bus.ReqA[gi*XL +: XL] : 0);
            chk("srcb", bus.MulSrcB, eg != 0 ? bus.ReqB[gi*XL +: XL] : 0);
            chk("funct3", bus.MulFunct3, eg != 0 ? bus.ReqFunct3[gi*3 +: 3] : 0);
            chk("flush", bus.MulFlushM, 0);
            for (int i = 0; i < 2; i++) begin
                if (pp[i]) void'(q[i].pop_front());
                if (bus.Kill[i]) q[i].delete();
            end
            if (eg != 0) begin
                q[gi].push_back('{resf(bus.ReqA[gi*XL +: XL], bus.ReqB[gi*XL +: XL], bus.ReqFunct3[gi*3 +: 2]),
                                 bus.ReqTag[gi*TW +: TW], cyc + 2});
                mptr = eg[0];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [XL-1:0] a, input logic [XL-1:0] b, input logic [2:0] f,
                          input logic [XL-1:0] exp, input string nm);
        bus.ReqValid  = 2'b01;
        bus.ReqA      = {32'h0, a};
        bus.ReqB      = {32'h0, b};
        bus.ReqFunct3 = {3'b000, f};
        bus.ReqTag    = 8'h05;
        bus.ResReady  = 2'b11;
        @(negedge clk);
        chk({nm, "_accept"}, bus.ReqReady[0], 1);
        step();
        bus.ReqValid = 2'b00;
        @(negedge clk);
        chk({nm, "_early"}, bus.ResValid, 0);
        step();
        @(negedge clk);
        chk({nm, "_valid"}, bus.ResValid, 2'b01);
        chk(nm, bus.ResData[XL-1:0], exp);
        step();
    endtask

    task automatic drain();
        bus.ReqValid = 2'b00;
        bus.Kill     = 2'b00;
        bus.ResReady = 2'b11;
        repeat (4) step();
    endtask

    logic [3:0] t0, t1, tg1;
    logic       saw0, saw1;
    int         acc;

    initial begin
        bus.ReqValid = 0; bus.ReqA = 0; bus.ReqB = 0; bus.ReqFunct3 = 0;
        bus.ReqTag = 0; bus.Kill = 0; bus.ResReady = 0;
        repeat (3) step();
        @(negedge clk);
        chk("init_stall", bus.MulStallM, 1);
        chk("init_ready", bus.ReqReady, 0);
        step();
        reset = 1'b1;

        single(32'h7, 32'hFFFFFFFD, 3'b000, 32'hFFFFFFEB, "mul");
        single(32'h7, 32'hFFFFFFFD, 3'b001, 32'hFFFFFFFF, "mulh");
        single(32'h7, 32'hFFFFFFFD, 3'b011, 32'h00000006, "mulhu");
        single(32'hFFFFFFFF, 32'h2, 3'b010, 32'hFFFFFFFF, "mulhsu");

        // Contention from a fresh pointer
        reset = 1'b0;
        step();
        reset = 1'b1;
        t0 = 4'h0; t1 = 4'h8;
        bus.ResReady = 2'b11;
        for (int k = 0; k < 6; k++) begin
            bus.ReqValid = 2'b11;
            bus.ReqTag   = {t1, t0};
            @(negedge clk);
            chk("rr_grant", bus.ReqReady, (k % 2) != 0 ? 2'b10 : 2'b01);
            if (bus.ReqReady[0]) t0++; else t1++;
            step();
        end
        drain();

        // Backpressure on requester 0
        acc = 0;
        bus.ReqValid = 2'b01;
        bus.ResReady = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.ReqReady[0]) acc++;
            step();
        end
        chk("bp_accepts", acc, 2);
        @(negedge clk);
        chk("bp_blocked", bus.ReqReady[0], 0);
        bus.ResReady = 2'b01;
        @(negedge clk);
        chk("bp_pop_valid", bus.ResValid[0], 1);
        chk("bp_reuse", bus.ReqReady[0], 1);
        step();
        bus.ResReady = 2'b00;
        @(negedge clk);
        chk("bp_full_again", bus.ReqReady[0], 0);
        step();
        drain();

        // Kill requester 0 one cycle after its accept; requester 1 unaffected
        bus.ReqValid = 2'b01;
        bus.ReqTag   = 8'hBA;
        @(negedge clk);
        chk("kill_acc0", bus.ReqReady[0], 1);
        step();
        bus.ReqValid = 2'b10;
        bus.Kill     = 2'b01;
        @(negedge clk);
        chk("kill_acc1", bus.ReqReady, 2'b10);
        step();
        bus.ReqValid = 2'b00;
        bus.Kill     = 2'b00;
        saw0 = 1'b0; saw1 = 1'b0; tg1 = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            saw0 |= bus.ResValid[0];
            if (bus.ResValid[1]) begin saw1 = 1'b1; tg1 = bus.ResTag[7:4]; end
            step();
        end
        chk("kill_no_res0", saw0, 0);
        chk("kill_res1", saw1, 1);
        chk("kill_tag1", tg1, 4'hB);

        // Reset one cycle after accept
        bus.ReqValid = 2'b01;
        @(negedge clk);
        chk("rmid_acc", bus.ReqReady[0], 1);
        step();
        bus.ReqValid = 2'b00;
        reset = 1'b0;
        @(negedge clk);
        chk("rmid_resvalid", bus.ResValid, 0);
        chk("rmid_stall", bus.MulStallM, 1);
        step();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rmid_discard", bus.ResValid, 0);
            step();
        end
        single(32'h3, 32'h5, 3'b000, 32'hF, "rmid_new");

        // Idle: pointer must survive (last grant went to requester 0)
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_stall", bus.MulStallM, 1);
            chk("idle_srca", bus.MulSrcA, 0);
            step();
        end
        bus.ReqValid = 2'b11;
        @(negedge clk);
        chk("idle_ptr", bus.ReqReady, 2'b10);
        step();
        drain();

        for (int k = 0; k < 3000; k++) begin
            reset         = $urandom_range(0, 299) != 0;
            bus.ReqValid  = 2'($urandom);
            bus.ResReady  = 2'($urandom);
            bus.Kill      = {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
            bus.ReqA      = {$urandom, $urandom};
            bus.ReqB      = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) bus.ReqA = {32'hFFFFFFFF, 32'h80000000};
            bus.ReqFunct3 = 6'($urandom);
            bus.ReqTag    = 8'($urandom);
            step();
        end
        reset = 1'b1;
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
